// File: rtl/cpu_pipe.sv
// Three-stage register-register CPU core: IR latch, read/execute with WB forwarding, writeback.
// Includes a preload port, a debug register read port and a retired-instruction counter.
`timescale 1ns/1ps
module cpu_pipe #(
    parameter int d_width   = 32,
    parameter int reg_ct    = 32,
    parameter int raddr_sz  = $clog2(reg_ct),
    parameter int op_width  = 3,
    parameter int ins_width = op_width + 3*raddr_sz,
    parameter int cnt_width = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [ins_width-1:0] ins,
    input  logic                 ld_en,
    input  logic [raddr_sz-1:0]  ld_addr,
    input  logic [d_width-1:0]   ld_data,
    output logic                 wb_valid,
    output logic [raddr_sz-1:0]  wb_addr,
    output logic [d_width-1:0]   wb_data,
    input  logic [raddr_sz-1:0]  dbg_addr,
    output logic [d_width-1:0]   dbg_data,
    output logic [cnt_width-1:0] retired
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NAND = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SGT  = 3'b101,
        OP_SLL  = 3'b110,
        OP_SRL  = 3'b111
    } op_e;

    logic [ins_width-1:0] ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [raddr_sz-1:0]  wb_addr_q, wb_addr_d;
    logic [d_width-1:0]   wb_data_q, wb_data_d;
    logic [cnt_width-1:0] retired_q, retired_d;
    logic [d_width-1:0]   regs_q [reg_ct];
    logic [d_width-1:0]   regs_d [reg_ct];

    op_e                  ir_op;
    logic [raddr_sz-1:0]  ir_rd, ir_rs1, ir_rs2;
    logic [d_width-1:0]   opa, opb, alu_res;

    assign ins_ready = rst_n;

    assign ir_op  = op_e'(ir_q[ins_width-1 -: op_width]);
    assign ir_rd  = ir_q[3*raddr_sz-1 -: raddr_sz];
    assign ir_rs1 = ir_q[2*raddr_sz-1 -: raddr_sz];
    assign ir_rs2 = ir_q[raddr_sz-1:0];

    // Only the WB result is forwarded; a same-cycle preload is not visible to S2.
    assign opa = (wb_valid_q && (wb_addr_q == ir_rs1)) ? wb_data_q : regs_q[ir_rs1];
    assign opb = (wb_valid_q && (wb_addr_q == ir_rs2)) ? wb_data_q : regs_q[ir_rs2];

    always_comb begin
        alu_res = '0;
        case (ir_op)
            OP_ADD:  alu_res = opa + opb;
            OP_AND:  alu_res = opa & opb;
            OP_NAND: alu_res = ~(opa & opb);
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SGT:  alu_res = d_width'(opa > opb);
            OP_SLL:  alu_res = (int'(ir_rs2) >= d_width) ? '0 : (opa << ir_rs2);
            OP_SRL:  alu_res = (int'(ir_rs2) >= d_width) ? '0 : (opa >> ir_rs2);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        if (ins_valid && ins_ready) begin
            ir_d       = ins;
            ir_valid_d = 1'b1;
        end
        wb_valid_d = ir_valid_q;
        wb_addr_d  = ir_rd;
        wb_data_d  = alu_res;
        retired_d  = wb_valid_q ? retired_q + 1'b1 : retired_q;
    end

    // Preload applied first so a writeback to the same register overrides it.
    always_comb begin
        for (int unsigned i = 0; i < reg_ct; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_en && (int'(ld_addr) == int'(i)))
                regs_d[i] = ld_data;
            if (wb_valid_q && (int'(wb_addr_q) == int'(i)))
                regs_d[i] = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
            for (int unsigned i = 0; i < reg_ct; i++)
                regs_q[i] <= '0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_d;
            for (int unsigned i = 0; i < reg_ct; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign retired  = retired_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
